// File: rtl/alu_exec_8.sv
// alu_exec_8: 8-bit ALU execute stage with register-file writeback and an 8-cycle shift-add multiplier.
// Ports: clk, rst (async, active-high); issue_valid/issue_ready handshake with op, src_a, src_b, dst;
// writeback wb_en/wb_addr/wb_data; registered flags {Z,C,N,V}.
module alu_exec_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic [3:0] op,
  input  logic [7:0] src_a,
  input  logic [7:0] src_b,
  input  logic [3:0] dst,
  output logic       wb_en,
  output logic [3:0] wb_addr,
  output logic [7:0] wb_data,
  output logic [3:0] flags
);
  localparam logic [1:0] IDLE = 2'd0, MUL_RUN = 2'd1, WB_LO = 2'd2, WB_HI = 2'd3;
  logic [1:0]  state;
  logic [15:0] mul_a, acc, acc_next;
  logic [7:0]  mul_b;
  logic [2:0]  cnt;
  logic [3:0]  mul_dst;
  logic [8:0]  s9;
  logic [7:0]  res;
  logic        c_out, v_out, cin, take;
  assign cin = flags[2];
  assign issue_ready = (state == IDLE) || (state == WB_HI);
  assign take = issue_valid && issue_ready;
  assign acc_next = acc + (mul_b[0] ? mul_a : 16'd0);
  always_comb begin
    s9 = 9'd0;
    res = 8'd0;
    c_out = 1'b0;
    v_out = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        s9 = {1'b0, src_a} + {1'b0, src_b} + {8'd0, op == 4'd1 && cin};
        res = s9[7:0];
        c_out = s9[8];
        v_out = (src_a[7] == src_b[7]) && (res[7] != src_a[7]);
      end
      // s9[8] of the 9-bit difference is the borrow
      4'd2, 4'd3, 4'd12: begin
        s9 = {1'b0, src_a} - {1'b0, src_b} - {8'd0, op == 4'd3 && cin};
        res = s9[7:0];
        c_out = s9[8];
        v_out = (src_a[7] != src_b[7]) && (res[7] != src_a[7]);
      end
      4'd4: res = src_a & src_b;
      4'd5: res = src_a | src_b;
      4'd6: res = src_a ^ src_b;
      4'd7: res = ~src_a;
      4'd8: begin
        res = {src_a[6:0], 1'b0};
        c_out = src_a[7];
      end
      4'd9: begin
        res = {1'b0, src_a[7:1]};
        c_out = src_a[0];
      end
      4'd10: begin
        res = {src_a[6:0], cin};
        c_out = src_a[7];
      end
      4'd11: res = src_b;
      4'd13: begin
        res = src_a + 8'd1;
        c_out = cin;
        v_out = src_a == 8'h7F;
      end
      4'd14: begin
        res = src_a - 8'd1;
        c_out = cin;
        v_out = src_a == 8'h80;
      end
      default: res = 8'd0;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wb_en <= 1'b0;
      wb_addr <= 4'd0;
      wb_data <= 8'd0;
      flags <= 4'd0;
      mul_a <= 16'd0;
      mul_b <= 8'd0;
      acc <= 16'd0;
      cnt <= 3'd0;
      mul_dst <= 4'd0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        MUL_RUN: begin
          acc <= acc_next;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt <= cnt + 3'd1;
          // last partial product is folded in on the same edge the low byte is written
          if (cnt == 3'd7) begin
            state <= WB_LO;
            wb_en <= 1'b1;
            wb_addr <= mul_dst;
            wb_data <= acc_next[7:0];
            flags <= {acc_next == 16'd0, |acc_next[15:8], acc_next[15], 1'b0};
          end
        end
        WB_LO: begin
          state <= WB_HI;
          wb_en <= 1'b1;
          wb_addr <= mul_dst + 4'd1;
          wb_data <= acc[15:8];
        end
        default: begin
          state <= IDLE;
          if (take) begin
            if (op == 4'd15) begin
              state <= MUL_RUN;
              mul_a <= {8'd0, src_a};
              mul_b <= src_b;
              acc <= 16'd0;
              cnt <= 3'd0;
              mul_dst <= dst;
            end else begin
              wb_en <= op != 4'd12;
              wb_addr <= dst;
              wb_data <= res;
              flags <= {res == 8'd0, c_out, res[7], v_out};
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_8.sv
// tb_alu_exec_8: directed-vector self-checking bench for alu_exec_8.
module tb_alu_exec_8;
  logic       clk = 1'b0, rst = 1'b1, issue_valid = 1'b0, issue_ready;
  logic [3:0] op = 4'd0, dst = 4'd0, wb_addr, flags;
  logic [7:0] src_a = 8'd0, src_b = 8'd0, wb_data;
  logic       wb_en;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a, b;
    logic [3:0] d;
    logic       en;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;
  vec_t tbl [19];
  alu_exec_8 dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flags(flags)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input logic [3:0] d);
    issue_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    dst = d;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl = '{
      '{4'd0,  8'hFF, 8'h01, 4'd1,  1'b1, 8'h00, 4'b1100},
      '{4'd1,  8'h00, 8'h00, 4'd2,  1'b1, 8'h01, 4'b0000},
      '{4'd2,  8'h03, 8'h05, 4'd3,  1'b1, 8'hFE, 4'b0110},
      '{4'd3,  8'h05, 8'h03, 4'd4,  1'b1, 8'h01, 4'b0000},
      '{4'd4,  8'hF0, 8'h3C, 4'd5,  1'b1, 8'h30, 4'b0000},
      '{4'd5,  8'h0F, 8'hF0, 4'd6,  1'b1, 8'hFF, 4'b0010},
      '{4'd6,  8'hAA, 8'hAA, 4'd7,  1'b1, 8'h00, 4'b1000},
      '{4'd7,  8'h0F, 8'h00, 4'd8,  1'b1, 8'hF0, 4'b0010},
      '{4'd8,  8'h81, 8'h00, 4'd9,  1'b1, 8'h02, 4'b0100},
      '{4'd10, 8'h40, 8'h00, 4'd10, 1'b1, 8'h81, 4'b0010},
      '{4'd9,  8'h81, 8'h00, 4'd11, 1'b1, 8'h40, 4'b0100},
      '{4'd10, 8'h80, 8'h00, 4'd12, 1'b1, 8'h01, 4'b0100},
      '{4'd11, 8'h00, 8'h5A, 4'd13, 1'b1, 8'h5A, 4'b0000},
      '{4'd13, 8'h7F, 8'h00, 4'd14, 1'b1, 8'h80, 4'b0011},
      '{4'd0,  8'hFF, 8'hFF, 4'd15, 1'b1, 8'hFE, 4'b0110},
      '{4'd14, 8'h80, 8'h00, 4'd0,  1'b1, 8'h7F, 4'b0101},
      '{4'd13, 8'hFF, 8'h00, 4'd1,  1'b1, 8'h00, 4'b1100},
      '{4'd3,  8'h80, 8'h01, 4'd2,  1'b1, 8'h7E, 4'b0001},
      '{4'd12, 8'h01, 8'h02, 4'd3,  1'b0, 8'h00, 4'b0110}
    };
    #2;
    check("rst_wb_en", 16'(wb_en), 16'd0);
    check("rst_ready", 16'(issue_ready), 16'd1);
    check("rst_out", {wb_addr, wb_data, flags}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'd0, 8'h7F, 8'h01, 4'd3);
    @(negedge clk);
    issue_valid = 1'b0;
    check("add_en", 16'(wb_en), 16'd1);
    check("add_wb", {4'd0, wb_addr, wb_data}, {4'd0, 4'd3, 8'h80});
    check("add_flags", 16'(flags), 16'b0011);
    drive(4'd2, 8'h10, 8'h20, 4'd5);
    @(negedge clk);
    drive(4'd12, 8'h42, 8'h42, 4'd9);
    check("sub_wb", {3'd0, wb_en, wb_addr, wb_data}, {3'd0, 1'b1, 4'd5, 8'hF0});
    check("sub_flags", 16'(flags), 16'b0110);
    @(negedge clk);
    issue_valid = 1'b0;
    check("cmp_en", 16'(wb_en), 16'd0);
    check("cmp_flags", 16'(flags), 16'b1000);
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d);
      @(negedge clk);
      check($sformatf("vec%0d_en", i), 16'(wb_en), 16'(tbl[i].en));
      if (tbl[i].en) check($sformatf("vec%0d_wb", i), {4'd0, wb_addr, wb_data}, {4'd0, tbl[i].d, tbl[i].r});
      check($sformatf("vec%0d_flags", i), 16'(flags), 16'(tbl[i].f));
    end
    issue_valid = 1'b0;
    @(negedge clk);
    drive(4'd15, 8'hFF, 8'hFF, 4'd15);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) drive(4'd0, 8'h00, 8'h00, 4'd4);
      if (k == 1) issue_valid = 1'b0;
      check($sformatf("mul1_ready_t%0d", k), 16'(issue_ready), 16'(k > 9));
      check($sformatf("mul1_en_t%0d", k), 16'(wb_en), 16'(k == 9 || k == 10));
      if (k == 9) begin
        check("mul1_lo", {4'd0, wb_addr, wb_data}, {4'd0, 4'd15, 8'h01});
        check("mul1_flags", 16'(flags), 16'b0110);
      end
      if (k == 10) check("mul1_hi", {4'd0, wb_addr, wb_data}, {4'd0, 4'd0, 8'hFE});
    end
    drive(4'd15, 8'h80, 8'h02, 4'd7);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) drive(4'd0, 8'h01, 8'h01, 4'd2);
      check($sformatf("mul2_en_t%0d", k), 16'(wb_en), 16'(k >= 9 && k <= 11));
      if (k == 9) begin
        check("mul2_lo", {4'd0, wb_addr, wb_data}, {4'd0, 4'd7, 8'h00});
        check("mul2_flags", 16'(flags), 16'b0100);
      end
      if (k == 10) check("mul2_hi", {4'd0, wb_addr, wb_data}, {4'd0, 4'd8, 8'h01});
      if (k == 11) begin
        check("held_add_wb", {4'd0, wb_addr, wb_data}, {4'd0, 4'd2, 8'h02});
        check("held_add_flags", 16'(flags), 16'b0000);
        issue_valid = 1'b0;
      end
    end
    drive(4'd15, 8'hFF, 8'hFF, 4'd4);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    issue_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_ready", 16'(issue_ready), 16'd1);
    check("abort_out", {3'd0, wb_en, wb_addr, wb_data}, 16'd0);
    check("abort_flags", 16'(flags), 16'd0);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("abort_en_t%0d", k), 16'(wb_en), 16'd0);
    end
    drive(4'd0, 8'h80, 8'h80, 4'd6);
    @(negedge clk);
    issue_valid = 1'b0;
    check("post_add_wb", {3'd0, wb_en, wb_addr, wb_data}, {3'd0, 1'b1, 4'd6, 8'h00});
    check("post_add_flags", 16'(flags), 16'b1101);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
